dcache_controller: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache between the MEM stage and data_memory.

---
 rtl/dcache_pkg.sv | 23 ++
 rtl/dcache_line_store.sv | 66 ++++++
 rtl/dcache_controller.sv | 155 +++++++++++++++
 tb/tb_dcache_controller.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the direct-mapped data cache.
//   - FSM state encoding
//   - line/word/offset widths
//   - tag width helper derived from address and index widths
package dcache_pkg;

  localparam int LINE_W      = 128;
  localparam int WORD_W      = 32;
  localparam int OFFSET_BITS = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WB        = 2'd1,
    FILL_REQ  = 2'd2,
    FILL_WAIT = 2'd3
  } dcache_state_e;

  // Tag is everything above the index and word-offset fields.
  function automatic int tag_width(input int addr_w, input int index_bits);
    return addr_w - index_bits - OFFSET_BITS;
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// dcache_line_store: data, tag, valid and dirty arrays for the cache.
// Ports:
//   clk, rst                      clock, async active-high reset (valid/dirty only)
//   rd_index                      combinational read index
//   rd_line/rd_tag/rd_valid/rd_dirty  contents of the selected line
//   word_we/word_index/word_offset/word_data  single-word store port, sets dirty
//   line_we/line_index/line_tag/line_data     whole-line fill port, sets valid, clears dirty
// Data and tag arrays are deliberately not reset; valid bits gate their use.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_W      = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic [LINE_W-1:0]     rd_line,
  output logic [TAG_W-1:0]      rd_tag,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  input  logic                  word_we,
  input  logic [INDEX_BITS-1:0] word_index,
  input  logic [1:0]            word_offset,
  input  logic [WORD_W-1:0]     word_data,
  input  logic                  line_we,
  input  logic [INDEX_BITS-1:0] line_index,
  input  logic [TAG_W-1:0]      line_tag,
  input  logic [LINE_W-1:0]     line_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINE_W-1:0] data_arr [LINES];
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;

  assign rd_line  = data_arr[rd_index];
  assign rd_tag   = tag_arr[rd_index];
  assign rd_valid = valid[rd_index];
  assign rd_dirty = dirty[rd_index];

  // Fill and store-hit never coincide (FILL_WAIT vs IDLE); fill still wins.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_arr[line_index] <= line_data;
      tag_arr[line_index]  <= line_tag;
    end else if (word_we) begin
      data_arr[word_index][{word_offset, 5'b00000} +: WORD_W] <= word_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (line_we) begin
      valid[line_index] <= 1'b1;
      dirty[line_index] <= 1'b0;
    end else if (word_we) begin
      dirty[word_index] <= 1'b1;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate data cache.
// Ports:
//   clk, rst                 clock, async active-high reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  MEM-stage word access (word address)
//   cpu_rdata                load data, valid when cpu_req & !cpu_stall
//   cpu_stall                pipeline freeze while a miss is serviced
//   mem_write                data_memory line write strobe (WB state only)
//   mem_read_address         line base address for fill
//   mem_write_address        line base address for writeback
//   mem_write_data           victim line, word0 in [31:0]
//   mem_read_data            fill line, valid one cycle after mem_read_address
//   hit_count/miss_count     wrapping event counters
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | serve hits; on a miss latch index/tag and leave
// WB        | dirty victim line driven to memory with mem_write=1
// FILL_REQ  | fill address presented to data_memory
// FILL_WAIT | fill data captured into the line; tag set, valid, clean
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int INDEX_BITS = 6,
  parameter int LINE_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [WORD_W-1:0]            cpu_wdata,
  output logic [WORD_W-1:0]            cpu_rdata,
  output logic                         cpu_stall,
  output logic                         mem_write,
  output logic [ADDR_W-1:0]            mem_read_address,
  output logic [ADDR_W-1:0]            mem_write_address,
  output logic [LINE_WORDS*WORD_W-1:0] mem_write_data,
  input  logic [LINE_WORDS*WORD_W-1:0] mem_read_data,
  output logic [31:0]                  hit_count,
  output logic [31:0]                  miss_count
);

  localparam int TAG_W = tag_width(ADDR_W, INDEX_BITS);

  localparam logic [1:0] S_IDLE      = IDLE;
  localparam logic [1:0] S_WB        = WB;
  localparam logic [1:0] S_FILL_REQ  = FILL_REQ;
  localparam logic [1:0] S_FILL_WAIT = FILL_WAIT;

  logic [1:0] state;
  logic [1:0] state_nxt;

  logic [1:0]            cpu_offset;
  logic [INDEX_BITS-1:0] cpu_index;
  logic [TAG_W-1:0]      cpu_tag;

  // Miss address is latched so a request dropped mid-miss still installs.
  logic [INDEX_BITS-1:0] miss_index;
  logic [TAG_W-1:0]      miss_tag;

  logic [INDEX_BITS-1:0] rd_index;
  logic [LINE_W-1:0]     rd_line;
  logic [TAG_W-1:0]      rd_tag;
  logic                  rd_valid;
  logic                  rd_dirty;

  logic in_idle;
  logic hit;
  logic idle_hit;
  logic idle_miss;
  logic store_hit;
  logic fill_we;

  assign cpu_offset = cpu_addr[1:0];
  assign cpu_index  = cpu_addr[INDEX_BITS+1:2];
  assign cpu_tag    = cpu_addr[ADDR_W-1:INDEX_BITS+2];

  assign in_idle   = (state == S_IDLE);
  assign rd_index  = in_idle ? cpu_index : miss_index;
  assign hit       = rd_valid && (rd_tag == cpu_tag);
  assign idle_hit  = in_idle && hit;
  assign idle_miss = in_idle && cpu_req && !hit;
  assign store_hit = idle_hit && cpu_req && cpu_we;
  assign fill_we   = (state == S_FILL_WAIT);

  dcache_line_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_line_store (
    .clk         (clk),
    .rst         (rst),
    .rd_index    (rd_index),
    .rd_line     (rd_line),
    .rd_tag      (rd_tag),
    .rd_valid    (rd_valid),
    .rd_dirty    (rd_dirty),
    .word_we     (store_hit),
    .word_index  (cpu_index),
    .word_offset (cpu_offset),
    .word_data   (cpu_wdata),
    .line_we     (fill_we),
    .line_index  (miss_index),
    .line_tag    (miss_tag),
    .line_data   (mem_read_data)
  );

  assign cpu_stall = cpu_req && !idle_hit;
  // Gated to zero off a hit so reset and miss cycles show no stale data.
  assign cpu_rdata = (cpu_req && idle_hit) ? rd_line[{cpu_offset, 5'b00000} +: WORD_W] : '0;

  // State is cleared asynchronously, so a WB cut by reset drops mem_write at once.
  assign mem_write         = (state == S_WB);
  assign mem_write_address = {rd_tag, miss_index, 2'b00};
  assign mem_write_data    = rd_line;
  assign mem_read_address  = (state == S_FILL_REQ || state == S_FILL_WAIT)
                             ? {miss_tag, miss_index, 2'b00}
                             : {cpu_tag, cpu_index, 2'b00};

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (idle_miss) begin
          state_nxt = (rd_valid && rd_dirty) ? S_WB : S_FILL_REQ;
        end
      end
      S_WB:        state_nxt = S_FILL_REQ;
      S_FILL_REQ:  state_nxt = S_FILL_WAIT;
      S_FILL_WAIT: state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      miss_index <= '0;
      miss_tag   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= state_nxt;
      if (idle_miss) begin
        miss_index <= cpu_index;
        miss_tag   <= cpu_tag;
        miss_count <= miss_count + 32'd1;
      end
      if (cpu_req && idle_hit) begin
        hit_count <= hit_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;

  logic         clk;
  logic         rst;
  logic         cpu_req;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic         mem_write;
  logic [31:0]  mem_read_address;
  logic [31:0]  mem_write_address;
  logic [127:0] mem_write_data;
  logic [127:0] mem_read_data;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  dcache_controller dut (
    .clk               (clk),
    .rst               (rst),
    .cpu_req           (cpu_req),
    .cpu_we            (cpu_we),
    .cpu_addr          (cpu_addr),
    .cpu_wdata         (cpu_wdata),
    .cpu_rdata         (cpu_rdata),
    .cpu_stall         (cpu_stall),
    .mem_write         (mem_write),
    .mem_read_address  (mem_read_address),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_read_data     (mem_read_data),
    .hit_count         (hit_count),
    .miss_count        (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_memory model: mem[i]=i unless overwritten by a writeback.
  logic [31:0] mem_wr [int unsigned];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_wr.exists(a)) return mem_wr[a];
    return a;
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    return {mem_word(a + 32'd3), mem_word(a + 32'd2), mem_word(a + 32'd1), mem_word(a)};
  endfunction

  always @(posedge clk) begin
    if (mem_write) begin
      for (int k = 0; k < 4; k++) begin
        mem_wr[mem_write_address + 32'(k)] = mem_write_data[k*32 +: 32];
      end
    end
    mem_read_data <= mem_line(mem_read_address);
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          we;
    logic [31:0] rdata;
    int          stalls;
    string       name;
  } exp_t;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
  } wb_t;

  exp_t sb_q[$];
  wb_t  wb_q[$];

  // Response monitor: counts stall cycles per request, compares on accept.
  int stall_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_cnt = 0;
    end else if (cpu_req) begin
      if (cpu_stall) begin
        stall_cnt++;
      end else begin
        if (sb_q.size() == 0) begin
          check("unexpected_accept", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_stalls"}, 128'(stall_cnt), 128'(e.stalls));
          if (!e.we) check({e.name, "_rdata"}, cpu_rdata, e.rdata);
        end
        stall_cnt = 0;
      end
    end
  end

  // Writeback monitor: every mem_write must match a queued expectation.
  always @(negedge clk) begin
    wb_t w;
    if (mem_write) begin
      if (wb_q.size() == 0) begin
        check("unexpected_mem_write", 1, 0);
      end else begin
        w = wb_q.pop_front();
        check("wb_addr", mem_write_address, w.addr);
        check("wb_data", mem_write_data, w.data);
      end
    end
  end

  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input int exp_stalls, input string nm);
    bit done;
    sb_q.push_back('{we, exp_rdata, exp_stalls, nm});
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!cpu_stall) done = 1'b1;
    end
    if (!done) check({nm, "_timeout"}, 0, 1);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", cpu_stall, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_hits", hit_count, 0);
    check("rst_misses", miss_count, 0);
    check("rst_rdata", cpu_rdata, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: cold load
    access(0, 32'h10, 0, 32'h10, 3, "t1_load10");
    check("t1_misses", miss_count, 1);
    check("t1_hits", hit_count, 1);

    // 2: rest of the line hits
    access(0, 32'h11, 0, 32'h11, 0, "t2_load11");
    access(0, 32'h12, 0, 32'h12, 0, "t2_load12");
    access(0, 32'h13, 0, 32'h13, 0, "t2_load13");
    check("t2_hits", hit_count, 4);

    // 3: store hit then read back
    access(1, 32'h12, 32'hDEADBEEF, 0, 0, "t3_store12");
    access(0, 32'h12, 0, 32'hDEADBEEF, 0, "t3_load12");
    check("t3_hits", hit_count, 6);

    // 4: conflict miss on dirty line -> writeback then fill
    wb_q.push_back('{32'h10, {32'h13, 32'hDEADBEEF, 32'h11, 32'h10}});
    access(0, 32'h112, 0, 32'h112, 4, "t4_load112");
    check("t4_misses", miss_count, 2);
    check("t4_hits", hit_count, 7);

    // 5: reset during FILL_WAIT of a clean miss
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h30;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst     = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    check("t5_stall", cpu_stall, 0);
    check("t5_mem_write", mem_write, 0);
    check("t5_hits", hit_count, 0);
    check("t5_misses", miss_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    access(0, 32'h10, 0, 32'h10, 3, "t5_load10");
    check("t5_misses_after", miss_count, 1);

    // 6: back-to-back stores into one missing line
    access(1, 32'h200, 32'hA5A50001, 0, 3, "t6_store200");
    access(1, 32'h201, 32'h5A5A0002, 0, 0, "t6_store201");
    check("t6_misses", miss_count, 2);
    access(0, 32'h200, 0, 32'hA5A50001, 0, "t6_load200");
    access(0, 32'h201, 0, 32'h5A5A0002, 0, "t6_load201");
    check("t6_hits", hit_count, 5);
    wb_q.push_back('{32'h200, {32'h203, 32'h202, 32'h5A5A0002, 32'hA5A50001}});
    access(0, 32'h300, 0, 32'h300, 4, "t6_evict300");
    check("t6_misses_evict", miss_count, 3);
    check("t6_hits_evict", hit_count, 6);

    repeat (2) @(posedge clk);
    check("sb_drained", 128'(sb_q.size()), 0);
    check("wb_drained", 128'(wb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
